// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the stopwatch time-keeping core.
package stopwatch_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        ADJ_RUN = 2'b00,
        ADJ_MIN = 2'b01,
        ADJ_SEC = 2'b10
    } adj_mode_t;

    localparam bcd_t BCD_TENS_MAX = 4'd5;
    localparam bcd_t BCD_ONES_MAX = 4'd9;

    // Saturating compare also folds any illegal code back to zero.
    function automatic bcd_t bcd_incr(input bcd_t digit, input bcd_t max_digit);
        bcd_t result;
        if (digit >= max_digit) begin
            result = 4'd0;
        end else begin
            result = digit + 4'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_mod60.sv
// Two-digit BCD counter 00..59; carry flags the increment that wraps 59 -> 00.
module bcd_mod60
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       carry
);

    bcd_t tens_r;
    bcd_t ones_r;
    bcd_t tens_nxt_s;
    bcd_t ones_nxt_s;
    logic ones_wrap_s;
    logic tens_wrap_s;

    // Next-digit logic: ones always step, tens only when ones wrap.
    always_comb begin
        ones_wrap_s = (ones_r >= BCD_ONES_MAX);
        tens_wrap_s = (tens_r >= BCD_TENS_MAX);
        tens_nxt_s  = tens_r;
        ones_nxt_s  = ones_r;
        carry       = 1'b0;
        if (inc) begin
            ones_nxt_s = bcd_incr(ones_r, BCD_ONES_MAX);
            if (ones_wrap_s) begin
                tens_nxt_s = bcd_incr(tens_r, BCD_TENS_MAX);
                carry      = tens_wrap_s;
            end else begin
                tens_nxt_s = tens_r;
            end
        end else begin
            ones_nxt_s = ones_r;
        end
    end

    // Digit registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tens_r <= 4'd0;
            ones_r <= 4'd0;
        end else begin
            tens_r <= tens_nxt_s;
            ones_r <= ones_nxt_s;
        end
    end

    assign tens = tens_r;
    assign ones = ones_r;

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch MM:SS core: 1 Hz counting, pause toggle, and resynchronised
// manual minute/second adjust steps gated by the adjust mode.
module stopwatch_counter
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       pause_toggle,
    input  logic [1:0] adj_state,
    input  logic       sig_minute_adj,
    input  logic       sig_second_adj,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       paused,
    output logic       rollover
);

    logic min_sync1_r, min_sync2_r, min_hist_r;
    logic sec_sync1_r, sec_sync2_r, sec_hist_r;
    logic paused_r;
    logic rollover_r;

    logic min_step_s, sec_step_s;
    logic run_mode_s, min_mode_s, sec_mode_s;
    logic count_en_s;
    logic sec_inc_s, min_inc_s;
    logic sec_carry_s, min_carry_s;
    logic wrap_s;

    // Two-flop synchronisers plus a history flop per adjust input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            min_sync1_r <= 1'b0;
            min_sync2_r <= 1'b0;
            min_hist_r  <= 1'b0;
            sec_sync1_r <= 1'b0;
            sec_sync2_r <= 1'b0;
            sec_hist_r  <= 1'b0;
        end else begin
            min_sync1_r <= sig_minute_adj;
            min_sync2_r <= min_sync1_r;
            min_hist_r  <= min_sync2_r;
            sec_sync1_r <= sig_second_adj;
            sec_sync2_r <= sec_sync1_r;
            sec_hist_r  <= sec_sync2_r;
        end
    end

    assign min_step_s = min_sync2_r & ~min_hist_r;
    assign sec_step_s = sec_sync2_r & ~sec_hist_r;

    // Mode decode and increment steering; 2'b11 behaves as run.
    always_comb begin
        run_mode_s = 1'b0;
        min_mode_s = 1'b0;
        sec_mode_s = 1'b0;
        case (adj_state)
            ADJ_MIN: min_mode_s = 1'b1;
            ADJ_SEC: sec_mode_s = 1'b1;
            default: run_mode_s = 1'b1;
        endcase
        count_en_s = run_mode_s & tick_1hz & ~paused_r;
        sec_inc_s  = (sec_mode_s & sec_step_s) | count_en_s;
        min_inc_s  = (min_mode_s & min_step_s) | (count_en_s & sec_carry_s);
        wrap_s     = count_en_s & sec_carry_s & min_carry_s;
    end

    bcd_mod60 u_seconds (
        .clk   (clk),
        .reset (reset),
        .inc   (sec_inc_s),
        .tens  (sec_tens),
        .ones  (sec_ones),
        .carry (sec_carry_s)
    );

    bcd_mod60 u_minutes (
        .clk   (clk),
        .reset (reset),
        .inc   (min_inc_s),
        .tens  (min_tens),
        .ones  (min_ones),
        .carry (min_carry_s)
    );

    // Pause state and registered rollover pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            paused_r   <= 1'b0;
            rollover_r <= 1'b0;
        end else begin
            paused_r   <= paused_r ^ pause_toggle;
            rollover_r <= wrap_s;
        end
    end

    assign paused   = paused_r;
    assign rollover = rollover_r;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed self-checking bench for stopwatch_counter.
module tb_stopwatch_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       pause_toggle = 1'b0;
    logic [1:0] adj_state = 2'b00;
    logic       sig_minute_adj = 1'b0;
    logic       sig_second_adj = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       paused, rollover;
    logic [15:0] digits;

    int vectors = 0;
    int miscompares = 0;
    int roll_cnt = 0;

    stopwatch_counter dut (
        .clk            (clk),
        .reset          (reset),
        .tick_1hz       (tick_1hz),
        .pause_toggle   (pause_toggle),
        .adj_state      (adj_state),
        .sig_minute_adj (sig_minute_adj),
        .sig_second_adj (sig_second_adj),
        .min_tens       (min_tens),
        .min_ones       (min_ones),
        .sec_tens       (sec_tens),
        .sec_ones       (sec_ones),
        .paused         (paused),
        .rollover       (rollover)
    );

    always #5 clk = ~clk;

    assign digits = {min_tens, min_ones, sec_tens, sec_ones};

    always @(negedge clk) begin
        if (rollover === 1'b1) roll_cnt <= roll_cnt + 1;
    end

    function automatic logic [15:0] to_bcd(input int mm, input int ss);
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic do_tick();
        @(posedge clk); #1 tick_1hz = 1'b1;
        @(posedge clk); #1 tick_1hz = 1'b0;
    endtask

    task automatic set_mode(input logic [1:0] m);
        @(posedge clk); #1 adj_state = m;
    endtask

    task automatic adj_pulse(input bit is_min, input int hi, input int lo);
        @(posedge clk); #1;
        if (is_min) sig_minute_adj = 1'b1;
        else        sig_second_adj = 1'b1;
        repeat (hi) @(posedge clk);
        #1 sig_minute_adj = 1'b0;
        sig_second_adj = 1'b0;
        repeat (lo) @(posedge clk);
        #1;
    endtask

    task automatic toggle_pause(input bit with_tick);
        @(posedge clk); #1 pause_toggle = 1'b1;
        tick_1hz = with_tick;
        @(posedge clk); #1 pause_toggle = 1'b0;
        tick_1hz = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        vectors++;
        if (digits !== 16'h0000 || paused !== 1'b0 || rollover !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got %h p=%b r=%b expected 0000 p=0 r=0", digits, paused, rollover);
        end
        reset = 1'b0;
    endtask

    task automatic test_count();
        int r0;
        r0 = roll_cnt;
        for (int i = 0; i < 75; i++) do_tick();
        vectors++;
        if (digits !== 16'h0115) begin
            miscompares++;
            $display("FAIL count_75: got %h expected 0115", digits);
        end
        vectors++;
        if (roll_cnt != r0) begin
            miscompares++;
            $display("FAIL count_no_rollover: got %0d pulses expected 0", roll_cnt - r0);
        end
    endtask

    task automatic test_rollover();
        int r0;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        set_mode(2'b01);
        repeat (59) adj_pulse(1'b1, 2, 2);
        set_mode(2'b10);
        repeat (58) adj_pulse(1'b0, 2, 2);
        set_mode(2'b00);
        vectors++;
        if (digits !== 16'h5958) begin
            miscompares++;
            $display("FAIL preload_5958: got %h expected 5958", digits);
        end
        r0 = roll_cnt;
        do_tick();
        vectors++;
        if (digits !== 16'h5959 || rollover !== 1'b0) begin
            miscompares++;
            $display("FAIL tick_5959: got %h r=%b expected 5959 r=0", digits, rollover);
        end
        do_tick();
        vectors++;
        if (digits !== 16'h0000 || rollover !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_0000: got %h r=%b expected 0000 r=1", digits, rollover);
        end
        @(posedge clk); #1;
        vectors++;
        if (rollover !== 1'b0 || roll_cnt != r0 + 1) begin
            miscompares++;
            $display("FAIL rollover_width: got r=%b pulses=%0d expected r=0 pulses=1", rollover, roll_cnt - r0);
        end
    endtask

    task automatic test_minute_adjust();
        logic [15:0] before_v, after_v;
        set_mode(2'b10);
        repeat (30) adj_pulse(1'b0, 2, 2);
        set_mode(2'b01);
        for (int p = 0; p < 31; p++) begin
            before_v = to_bcd(p, 30);
            after_v  = to_bcd(p + 1, 30);
            @(posedge clk); #1 sig_minute_adj = 1'b1;
            @(posedge clk); #1;
            @(posedge clk); #1;
            vectors++;
            if (digits !== before_v) begin
                miscompares++;
                $display("FAIL min_latency_early p=%0d: got %h expected %h", p, digits, before_v);
            end
            @(posedge clk); #1;
            vectors++;
            if (digits !== after_v) begin
                miscompares++;
                $display("FAIL min_latency_step p=%0d: got %h expected %h", p, digits, after_v);
            end
            repeat (5) @(posedge clk);
            #1 sig_minute_adj = 1'b0;
            tick_1hz = 1'b1;
            @(posedge clk); #1 tick_1hz = 1'b0;
            repeat (7) @(posedge clk);
            #1;
        end
        vectors++;
        if (digits !== 16'h3130) begin
            miscompares++;
            $display("FAIL min_adjust_31: got %h expected 3130", digits);
        end
    endtask

    task automatic test_second_adjust();
        int r0;
        r0 = roll_cnt;
        repeat (41) adj_pulse(1'b1, 2, 2);
        set_mode(2'b10);
        repeat (28) adj_pulse(1'b0, 2, 2);
        vectors++;
        if (digits !== 16'h1258) begin
            miscompares++;
            $display("FAIL preload_1258: got %h expected 1258", digits);
        end
        repeat (3) adj_pulse(1'b0, 2, 2);
        vectors++;
        if (digits !== 16'h1201) begin
            miscompares++;
            $display("FAIL sec_wrap_no_carry: got %h expected 1201", digits);
        end
        adj_pulse(1'b1, 2, 2);
        vectors++;
        if (digits !== 16'h1201 || roll_cnt != r0) begin
            miscompares++;
            $display("FAIL min_step_in_sec_mode: got %h pulses=%0d expected 1201 pulses=0", digits, roll_cnt - r0);
        end
    endtask

    task automatic test_pause();
        set_mode(2'b00);
        toggle_pause(1'b0);
        repeat (10) do_tick();
        vectors++;
        if (digits !== 16'h1201 || paused !== 1'b1) begin
            miscompares++;
            $display("FAIL paused_frozen: got %h p=%b expected 1201 p=1", digits, paused);
        end
        toggle_pause(1'b0);
        repeat (10) do_tick();
        vectors++;
        if (digits !== 16'h1211 || paused !== 1'b0) begin
            miscompares++;
            $display("FAIL resumed_10: got %h p=%b expected 1211 p=0", digits, paused);
        end
        toggle_pause(1'b1);
        vectors++;
        if (digits !== 16'h1212 || paused !== 1'b1) begin
            miscompares++;
            $display("FAIL toggle_tick_running: got %h p=%b expected 1212 p=1", digits, paused);
        end
        toggle_pause(1'b1);
        vectors++;
        if (digits !== 16'h1212 || paused !== 1'b0) begin
            miscompares++;
            $display("FAIL toggle_tick_paused: got %h p=%b expected 1212 p=0", digits, paused);
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        set_mode(2'b01);
        repeat (7) adj_pulse(1'b1, 1, 2);
        set_mode(2'b10);
        repeat (42) adj_pulse(1'b0, 1, 2);
        set_mode(2'b00);
        toggle_pause(1'b0);
        do_tick();
        vectors++;
        if (digits !== 16'h0742 || paused !== 1'b1) begin
            miscompares++;
            $display("FAIL narrow_preload_0742: got %h p=%b expected 0742 p=1", digits, paused);
        end
        @(posedge clk); #3 reset = 1'b1;
        #1;
        vectors++;
        if (digits !== 16'h0000 || paused !== 1'b0 || rollover !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got %h p=%b expected 0000 p=0", digits, paused);
        end
        #1 reset = 1'b0;
        tick_1hz = 1'b1;
        @(posedge clk); #1 tick_1hz = 1'b0;
        vectors++;
        if (digits !== 16'h0001) begin
            miscompares++;
            $display("FAIL first_tick_after_reset: got %h expected 0001", digits);
        end
        set_mode(2'b01);
        adj_pulse(1'b1, 1, 2);
        repeat (6) @(posedge clk);
        #1;
        vectors++;
        if (digits !== 16'h0101) begin
            miscompares++;
            $display("FAIL narrow_pulse_one_step: got %h expected 0101", digits);
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_rollover();
        test_minute_adjust();
        test_second_adjust();
        test_pause();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
